// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_gen
// Brief    : MSB-first serial word transmitter with repeats and idle gaps.
//            Macro SERIAL_PATTERN_GEN_PARITY_EN appends an even-parity bit.
// Revision : 1.0
// ============================================================================
module serial_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int GAP   = 2,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [RPT_W-1:0] repeat_cnt,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  // The parity bit occupies one extra slot after the LSB.
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST_SLOT = LAST_BIT;
`endif
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [RPT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    rem_d     = rem_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          shift_d   = data;
          hold_d    = data;
          rem_d     = repeat_cnt;
          bit_cnt_d = '0;
          x_d       = data[WIDTH-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q == LAST_SLOT) begin
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (HAS_GAP) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
            busy_d    = 1'b1;
          end else begin
            // Back-to-back copy: next MSB directly follows this word.
            shift_d   = hold_q;
            bit_cnt_d = '0;
            rem_d     = rem_q - 1'b1;
            x_d       = hold_q[WIDTH-1];
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          x_d       = shift_q[WIDTH-2];
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
          if (bit_cnt_q == LAST_BIT) begin
            x_d = ^hold_q;
          end
`endif
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_SHIFT;
          shift_d   = hold_q;
          bit_cnt_d = '0;
          rem_d     = rem_q - 1'b1;
          x_d       = hold_q[WIDTH-1];
          valid_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      rem_q     <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      rem_q     <= rem_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_gen
// Brief    : Directed, table-driven bench for serial_pattern_gen.
// Revision : 1.0
// ============================================================================
module tb_serial_pattern_gen;

  localparam int WIDTH = 16;
  localparam int GAP   = 2;
  localparam int RPT_W = 4;
  localparam int NONE  = -100;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam int WLEN = WIDTH + 1;
`else
  localparam int WLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data;
  logic [RPT_W-1:0] repeat_cnt;
  logic             x, valid, busy, done;

  int checks    = 0;
  int failures  = 0;
  int busy_seen = 0;
  int done_seen = 0;
  int cyc       = 0;
  int inject_at = NONE;

  always #5 clk = ~clk;

  serial_pattern_gen #(
    .WIDTH (WIDTH),
    .GAP   (GAP),
    .RPT_W (RPT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data       (data),
    .repeat_cnt (repeat_cnt),
    .x          (x),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rpt;
    logic        par;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare {x,valid,busy,done} at this negedge, then advance one cycle.
  task automatic step(input logic [3:0] exp, input string what);
    chk($sformatf("%s c%0d", what, cyc), {28'd0, x, valid, busy, done}, {28'd0, exp});
    if (busy) busy_seen++;
    if (done) done_seen++;
    if (cyc == inject_at) begin
      start = 1'b1;
      data  = 16'hFFFF;
    end else if (cyc == inject_at + 1) begin
      start = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic expect_stream(input logic [15:0] d, input int rpt, input logic par,
                               input string tag);
    logic ex;
    busy_seen = 0;
    done_seen = 0;
    cyc       = 0;
    for (int k = 0; k <= rpt; k++) begin
      for (int i = 0; i < WLEN; i++) begin
        ex = (i < WIDTH) ? d[WIDTH-1-i] : par;
        step({ex, 3'b110}, {tag, " bit"});
      end
      if (k < rpt) begin
        for (int g = 0; g < GAP; g++) step(4'b0010, {tag, " gap"});
      end
    end
    step(4'b0001, {tag, " done"});
  endtask

  task automatic pulse_start(input logic [15:0] d, input logic [3:0] r);
    data       = d;
    repeat_cnt = r;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    vecs[0] = '{16'b1001011010101100, 4'd0, 1'b0, 17};
    vecs[1] = '{16'hA5F0,             4'd2, 1'b0, 55};
    vecs[2] = '{16'h0001,             4'd0, 1'b1, 17};
    vecs[3] = '{16'h96AC,             4'd0, 1'b0, 17};
    vecs[4] = '{16'hFFFF,             4'd1, 1'b0, 36};
`else
    vecs[0] = '{16'b1001011010101100, 4'd0, 1'b0, 16};
    vecs[1] = '{16'hA5F0,             4'd2, 1'b0, 52};
    vecs[2] = '{16'h0001,             4'd0, 1'b1, 16};
    vecs[3] = '{16'h96AC,             4'd0, 1'b0, 16};
    vecs[4] = '{16'hFFFF,             4'd1, 1'b0, 34};
`endif
    rst        = 1'b1;
    start      = 1'b0;
    data       = '0;
    repeat_cnt = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {28'd0, x, valid, busy, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven transmissions.
    for (int v = 0; v < 5; v++) begin
      pulse_start(vecs[v].data, vecs[v].rpt);
      expect_stream(vecs[v].data, int'(vecs[v].rpt), vecs[v].par, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d busy cycles", v), busy_seen, vecs[v].busy_cyc);
      chk($sformatf("vec%0d done pulses", v), done_seen, 1);
      step(4'b0000, $sformatf("vec%0d idle", v));
    end

    // Start with different data mid-word is ignored.
    inject_at = 5;
    pulse_start(vecs[0].data, 4'd0);
    expect_stream(vecs[0].data, 0, vecs[0].par, "ignore");
    inject_at = NONE;
    chk("ignore done pulses", done_seen, 1);
    step(4'b0000, "ignore idle");
    step(4'b0000, "ignore idle");

    // Reset at bit 8 aborts with no done.
    pulse_start(vecs[0].data, 4'd0);
    busy_seen = 0;
    done_seen = 0;
    cyc       = 0;
    for (int i = 0; i < 8; i++) step({vecs[0].data[WIDTH-1-i], 3'b110}, "abort bit");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < WLEN + 4; i++) step(4'b0000, "abort idle");
    chk("abort done pulses", done_seen, 0);
    pulse_start(vecs[3].data, 4'd0);
    expect_stream(vecs[3].data, 0, vecs[3].par, "after_abort");
    chk("after_abort done pulses", done_seen, 1);

    // Start held through done: next MSB right after the done cycle.
    @(negedge clk);
    data       = 16'h0001;
    repeat_cnt = 4'd0;
    start      = 1'b1;
    @(negedge clk);
    expect_stream(16'h0001, 0, 1'b1, "b2b_first");
    start = 1'b0;
    expect_stream(16'h0001, 0, 1'b1, "b2b_second");
    chk("b2b second done pulses", done_seen, 1);
    step(4'b0000, "b2b idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Serial bit-pattern transmitter. It is the source-side counterpart to the single-bit serial sequence detectors in this codebase. It loads a parallel word and shifts it out MSB-first, one bit per clock, on a serial line `x`, with optional repeated transmission and idle gaps. It is used to drive detector blocks in system-level benches and on-chip self-test paths.

Parameters:
WIDTH, 16, number of bits per transmitted word (>=2)
GAP, 2, idle cycles inserted between repeated words (0 allowed = back-to-back)
RPT_W, 4, width of repeat-count input

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request transmission; sampled only when not busy
data  input  WIDTH  word to transmit, captured on accepted start
repeat_cnt  input  RPT_W  number of additional copies after the first (0 = send once)
x  output  1  serial data out, MSB first
valid  output  1  high while x carries a pattern bit
busy  output  1  high from first bit through last bit/gap of the final word
done  output  1  one-cycle pulse after the final bit of the final word

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge) gives x=0, valid=0, busy=0, done=0, state IDLE. Internal shift register, bit counter and repeat counter are cleared.
- States: IDLE, SHIFT, GAP.
- IDLE: x=0, valid=0, busy=0. If start=1 at edge N, capture data into shift and hold registers, load rem=repeat_cnt, and go to SHIFT. In the cycle after edge N: x=data[WIDTH-1], valid=1, busy=1. Latency from start sample to first bit is 1 edge.
- SHIFT: one bit per clock, MSB to LSB. Each bit is held exactly one cycle. A bit counter tracks position 0..WIDTH-1.
- After the LSB cycle:
  - if rem>0 and GAP>0: go to GAP for exactly GAP cycles (x=0, valid=0, busy=1), then reload the shift register from the hold register, rem<=rem-1, and re-enter SHIFT.
  - if rem>0 and GAP=0: reload and decrement immediately. The MSB of the next copy follows the LSB with no bubble.
  - if rem=0: go to IDLE. The next cycle has done=1, busy=0, valid=0, x=0.
- done is a single-cycle pulse. A start sampled during the done cycle is accepted normally, so the next word's MSB appears the following cycle (back-to-back operation).
- start while busy=1 is ignored. data and repeat_cnt are not re-sampled mid-transmission; the hold register keeps the captured copy.
- Reset mid-operation aborts immediately. Outputs return to reset values at that edge, and no done is generated.
- Total busy cycles = (repeat_cnt+1)*WIDTH + repeat_cnt*GAP.

Optional Feature:
Macro SERIAL_PATTERN_GEN_PARITY_EN.
- Defined: after each word's LSB, one extra bit is sent with valid=1 and x = even parity (XOR of all WIDTH data bits). Each word becomes WIDTH+1 cycles. Any GAP follows the parity bit, and done follows the final parity bit.
- Undefined: no parity bit, and timing is exactly as above.

Test Plan:
1. After rst, data=16'b1001011010101100, repeat_cnt=0, pulse start -> x over 16 consecutive cycles = 1,0,0,1,0,1,1,0,1,0,1,0,1,1,0,0 with valid=1. done=1 in cycle 17 only; busy high exactly 16 cycles.
2. data=16'hA5F0, repeat_cnt=2, GAP=2 -> three identical MSB-first copies separated by 2 cycles of x=0/valid=0. busy high 52 cycles, one done pulse.
3. During case 1, pulse start with data=16'hFFFF at bit 5 -> output sequence unchanged and no extra transmission.
4. Assert rst for one cycle at bit 8 of case 1 -> next cycle x=0, valid=0, busy=0, and done never asserts. A subsequent start transmits normally.
5. Hold start=1 with data=16'h0001 through a done cycle -> second word's MSB appears the cycle after done, with no idle gap.
6. With SERIAL_PATTERN_GEN_PARITY_EN: data=16'h0001 -> 17 valid bits, last bit x=1. data=16'h96AC -> 17th bit x=0.
